// File: rtl/instr_field_splitter_if.sv
// Instruction capture and split-field bus.
// The master drives a word in; the slave presents registered fields.
interface instr_field_splitter_if;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_valid;
  logic [5:0]  opc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  fun;
  logic [15:0] imm;
  logic [25:0] iindex;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        is_rtype;
  logic        is_jtype;

  modport master (
    output in_valid, instruction,
    input  out_valid, opc, rs, rt, rd, sa, fun,
    input  imm, iindex, imm_sext, imm_zext,
    input  is_rtype, is_jtype
  );

  modport slave (
    input  in_valid, instruction,
    output out_valid, opc, rs, rt, rd, sa, fun,
    output imm, iindex, imm_sext, imm_zext,
    output is_rtype, is_jtype
  );
endinterface

// File: rtl/instr_field_splitter.sv
// Registered MIPS instruction field extractor.
// Every field is sliced from the same captured word, no format masking.
module instr_field_splitter (
  input logic                  clk,
  input logic                  rst,
  instr_field_splitter_if.slave bus
);

  logic [31:0] w;
  logic [5:0]  w_opc;
  logic        w_rtype;
  logic        w_jtype;

  assign w = bus.instruction;
  assign w_opc = w[31:26];

  // Format flags from the incoming opcode, registered with the fields.
  always_comb begin
    w_rtype = (w_opc == 6'b000000);
    w_jtype = (w_opc[5:1] == 5'b00001);
  end

  // out_valid follows in_valid every cycle; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
    end
  end

  // Field registers load on in_valid and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.opc      <= '0;
      bus.rs       <= '0;
      bus.rt       <= '0;
      bus.rd       <= '0;
      bus.sa       <= '0;
      bus.fun      <= '0;
      bus.imm      <= '0;
      bus.iindex   <= '0;
      bus.imm_sext <= '0;
      bus.imm_zext <= '0;
      bus.is_rtype <= 1'b0;
      bus.is_jtype <= 1'b0;
    end else if (bus.in_valid) begin
      bus.opc      <= w_opc;
      bus.rs       <= w[25:21];
      bus.rt       <= w[20:16];
      bus.rd       <= w[15:11];
      bus.sa       <= w[10:6];
      bus.fun      <= w[5:0];
      bus.imm      <= w[15:0];
      bus.iindex   <= w[25:0];
      bus.imm_sext <= {{16{w[15]}}, w[15:0]};
      bus.imm_zext <= {16'h0000, w[15:0]};
      bus.is_rtype <= w_rtype;
      bus.is_jtype <= w_jtype;
    end
  end

endmodule

// File: tb/tb_instr_field_splitter.sv
// Scoreboard bench for instr_field_splitter.
// Directed words from the plan, then random words, resets and gaps.
module tb_instr_field_splitter;

  logic clk;
  logic rst;

  instr_field_splitter_if bus ();

  instr_field_splitter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [31:0] opc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] sa;
    logic [31:0] fun;
    logic [31:0] imm;
    logic [31:0] iindex;
    logic [31:0] sext;
    logic [31:0] zext;
    logic [31:0] rtype;
    logic [31:0] jtype;
  } exp_t;

  exp_t exp_q[$];

  int n_chk;
  int n_pass;
  int n_fail;

  // Reference state: last captured word, whether outputs are in reset state.
  logic [31:0] m_word;
  logic        m_clr;
  logic        m_valid;
  logic        done;

  function automatic exp_t model_out(input logic [31:0] w,
                                     input logic clr,
                                     input logic v);
    exp_t e;
    int unsigned u;
    int unsigned op;
    int unsigned im;
    u  = w;
    op = u / (1 << 26);
    im = u % 65536;
    e.v      = v ? 32'd1 : 32'd0;
    e.opc    = op;
    e.rs     = (u / (1 << 21)) % 32;
    e.rt     = (u / (1 << 16)) % 32;
    e.rd     = (u / (1 << 11)) % 32;
    e.sa     = (u / 64) % 32;
    e.fun    = u % 64;
    e.imm    = im;
    e.iindex = u % (1 << 26);
    e.zext   = im;
    e.sext   = (im >= 32768) ? (im + 32'hFFFF0000) : im;
    e.rtype  = (!clr && op == 0) ? 32'd1 : 32'd0;
    e.jtype  = (!clr && (op == 2 || op == 3)) ? 32'd1 : 32'd0;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic issue(input logic r, input logic v,
                       input logic [31:0] w);
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.instruction = w;
    if (r) begin
      m_word = 32'h0;
      m_clr = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_word = w;
        m_clr = 1'b0;
      end
    end
    exp_q.push_back(model_out(m_word, m_clr, m_valid));
  endtask

  // Monitor: after each edge, compare DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", {31'd0, bus.out_valid}, e.v);
        chk("opc", {26'd0, bus.opc}, e.opc);
        chk("rs", {27'd0, bus.rs}, e.rs);
        chk("rt", {27'd0, bus.rt}, e.rt);
        chk("rd", {27'd0, bus.rd}, e.rd);
        chk("sa", {27'd0, bus.sa}, e.sa);
        chk("fun", {26'd0, bus.fun}, e.fun);
        chk("imm", {16'd0, bus.imm}, e.imm);
        chk("iindex", {6'd0, bus.iindex}, e.iindex);
        chk("imm_sext", bus.imm_sext, e.sext);
        chk("imm_zext", bus.imm_zext, e.zext);
        chk("is_rtype", {31'd0, bus.is_rtype}, e.rtype);
        chk("is_jtype", {31'd0, bus.is_jtype}, e.jtype);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [31:0] w;
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;
    done = 1'b0;
    m_word = 32'h0;
    m_clr = 1'b1;
    m_valid = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.instruction = 32'hFFFFFFFF;

    issue(1'b1, 1'b1, 32'hFFFFFFFF);
    issue(1'b1, 1'b1, 32'hFFFFFFFF);
    issue(1'b0, 1'b1, 32'h012A4020);
    issue(1'b0, 1'b1, 32'h8D28FFFC);
    issue(1'b0, 1'b1, 32'h0C100010);
    issue(1'b0, 1'b1, 32'h08000000);
    issue(1'b0, 1'b1, 32'h012A4020);
    issue(1'b0, 1'b0, 32'h8D28FFFC);
    issue(1'b0, 1'b0, 32'h00000000);
    issue(1'b0, 1'b1, 32'h24018000);
    issue(1'b0, 1'b1, 32'h24017FFF);
    issue(1'b0, 1'b1, 32'h0C100010);
    issue(1'b1, 1'b1, 32'hFC00FFFF);
    issue(1'b0, 1'b0, 32'hFC00FFFF);
    issue(1'b0, 1'b1, 32'h00000000);

    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        w[31:27] = 5'b00001;
      end else if ($urandom_range(0, 3) == 0) begin
        w[31:26] = 6'b000000;
      end
      issue($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, w);
    end
    issue(1'b0, 1'b0, 32'h0);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
